// File: rtl/mult_sched.sv
// Round-robin scheduler sharing one Q15 multiplier (MULT_NORM) between N requesters.
// Two registered stages: operand stage S1 in front of the multiplier, result stage S2.
`timescale 1ns/1ps
module mult_sched #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      req_valid,
    output logic [N-1:0]      req_ready,
    input  logic [16*N-1:0]   req_a,
    input  logic [16*N-1:0]   req_b,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [15:0]       res_data,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    logic [IDW-1:0]     ptr;
    logic [IDW-1:0]     ptr_next;
    logic [IDW-1:0]     winner;
    logic               grant;
    logic               adv;

    logic               s1_valid;
    logic signed [15:0] s1_a;
    logic signed [15:0] s1_b;
    logic [IDW-1:0]     s1_id;
    logic [15:0]        mult_out;

    logic [15:0]        a_arr [N];
    logic [15:0]        b_arr [N];

    function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] p, input int k);
        return IDW'((int'(p) + k) % N);
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            a_arr[i] = req_a[16*i +: 16];
            b_arr[i] = req_b[16*i +: 16];
        end
    end

    assign adv = !res_valid || res_ready;

    // Scan from the farthest offset down so the closest requester to ptr wins.
    always_comb begin
        grant  = 1'b0;
        winner = '0;
        for (int k = N-1; k >= 0; k--) begin
            if (req_valid[rr_index(ptr, k)]) begin
                grant  = 1'b1;
                winner = rr_index(ptr, k);
            end
        end
    end

    assign ptr_next = (winner == IDW'(N-1)) ? '0 : winner + 1'b1;

    always_comb begin
        req_ready = '0;
        if (grant && adv && !rst)
            req_ready[winner] = 1'b1;
    end

    // MULT_NORM: 32-bit signed product, arithmetic shift by 15, truncate to 16 bits.
    assign mult_out = 16'((32'(s1_a) * 32'(s1_b)) >>> 15);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr       <= '0;
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_id     <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
        end else if (adv) begin
            res_valid <= s1_valid;
            if (s1_valid) begin
                res_data <= mult_out;
                res_id   <= s1_id;
            end
            s1_valid <= grant;
            if (grant) begin
                s1_a  <= a_arr[winner];
                s1_b  <= b_arr[winner];
                s1_id <= winner;
                ptr   <= ptr_next;
            end
        end
    end

    assign busy = s1_valid || res_valid;

endmodule

// File: tb/tb_mult_sched.sv
// Scoreboard bench for mult_sched: a spec-level model predicts grants and products,
// a separate monitor pops and compares whenever the DUT presents a result.
`timescale 1ns/1ps
module tb_mult_sched;
    localparam int N   = 4;
    localparam int IDW = 2;

    logic            clk;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [16*N-1:0] req_a;
    logic [16*N-1:0] req_b;
    logic            res_valid;
    logic            res_ready;
    logic [15:0]     res_data;
    logic [IDW-1:0]  res_id;
    logic            busy;

    mult_sched #(.N(N), .IDW(IDW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_id(res_id), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] data;
    } item_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    item_t       sb[$];
    int          obs_id[$];
    logic [15:0] obs_data[$];
    logic [N-1:0] acc;
    int          m_ptr;
    bit          m_s1v, m_s2v;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] qmul(input logic [15:0] a, input logic [15:0] b);
        int p;
        p = int'($signed(a)) * int'($signed(b));
        p = p >>> 15;
        return p[15:0];
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'hFFFF;
            default: return 16'($urandom);
        endcase
    endfunction

    // Reference model: round-robin pointer, two-slot pipeline occupancy, in-order queue.
    always @(negedge clk) begin
        bit           exp_adv;
        int           win;
        logic [N-1:0] exp_rdy;
        item_t        it;
        if (rst) begin
            m_ptr = 0; m_s1v = 0; m_s2v = 0; acc = '0;
            sb.delete();
            chk("ready_in_reset", 32'(req_ready), 32'd0);
        end else begin
            exp_adv = !m_s2v || res_ready;
            win = -1;
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_ptr + k) % N]) begin
                    win = (m_ptr + k) % N;
                    break;
                end
            end
            exp_rdy = '0;
            if (exp_adv && win >= 0) exp_rdy[win] = 1'b1;
            chk("req_ready", 32'(req_ready), 32'(exp_rdy));
            chk("res_valid", 32'(res_valid), 32'(m_s2v));
            chk("busy", 32'(busy), 32'(m_s1v || m_s2v));
            acc = req_valid & req_ready;
            if (exp_adv) begin
                m_s2v = m_s1v;
                m_s1v = (win >= 0);
                if (win >= 0) begin
                    it.id   = win;
                    it.data = qmul(req_a[16*win +: 16], req_b[16*win +: 16]);
                    sb.push_back(it);
                    m_ptr = (win + 1) % N;
                end
            end
        end
    end

    // Monitor: compare presented result with the oldest outstanding item.
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (sb.size() == 0) begin
                chk("res_unexpected", 32'(res_valid), 32'd0);
            end else begin
                chk("res_id", 32'(res_id), 32'(sb[0].id));
                chk("res_data", 32'(res_data), 32'(sb[0].data));
                if (res_ready) begin
                    obs_id.push_back(int'(res_id));
                    obs_data.push_back(res_data);
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int i, input logic [15:0] a, input logic [15:0] b);
        int n = 0;
        req_valid[i] = 1'b1;
        req_a[16*i +: 16] = a;
        req_b[16*i +: 16] = b;
        do begin
            tick();
            n++;
        end while (!acc[i] && n < 50);
        req_valid[i] = 1'b0;
        if (!acc[i]) chk("send_timeout", 32'(n), 32'd0);
    endtask

    task automatic drain();
        int n = 0;
        res_ready = 1'b1;
        while ((sb.size() != 0 || m_s1v || m_s2v) && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) chk("drain_timeout", 32'(n), 32'd0);
    endtask

    task automatic clear_obs();
        obs_id.delete();
        obs_data.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [15:0] ca [4];
        logic [15:0] cb [4];
        logic [15:0] cr [4];
        logic [15:0] exp_q[$];
        logic [15:0] a1, b1;
        int          n, n3;

        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; res_ready = 1'b0;
        #2;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_res_data", 32'(res_data), 32'd0);
        chk("rst_res_id", 32'(res_id), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        tick(); tick();
        rst = 1'b0;

        // Single op
        clear_obs();
        res_ready = 1'b1;
        send(0, 16'h4000, 16'h4000);
        drain();
        chk("single_count", 32'(obs_id.size()), 32'd1);
        if (obs_id.size() >= 1) begin
            chk("single_id", 32'(obs_id[0]), 32'd0);
            chk("single_data", 32'(obs_data[0]), 32'h2000);
        end
        chk("single_busy_clear", 32'(busy), 32'd0);

        // Arithmetic corners through requester 2
        ca = '{16'h7FFF, 16'h8000, 16'hC000, 16'h8000};
        cb = '{16'h7FFF, 16'h7FFF, 16'h4000, 16'h8000};
        cr = '{16'h7FFE, 16'h8001, 16'hE000, 16'h8000};
        clear_obs();
        for (int i = 0; i < 4; i++) send(2, ca[i], cb[i]);
        drain();
        chk("corner_count", 32'(obs_id.size()), 32'd4);
        for (int i = 0; i < obs_id.size() && i < 4; i++) begin
            chk("corner_id", 32'(obs_id[i]), 32'd2);
            chk("corner_data", 32'(obs_data[i]), 32'(cr[i]));
        end

        // Round robin from a fresh pointer
        rst = 1'b1; tick(); rst = 1'b0;
        clear_obs();
        for (int i = 0; i < N; i++) begin
            req_a[16*i +: 16] = 16'(100 * (i + 1));
            req_b[16*i +: 16] = 16'h7FFF;
        end
        req_valid = '1;
        res_ready = 1'b1;
        repeat (12) tick();
        req_valid = '0;
        drain();
        chk("rr_count", 32'(obs_id.size()), 32'd12);
        for (int k = 0; k < obs_id.size(); k++) begin
            chk("rr_id", 32'(obs_id[k]), 32'(k % 4));
            chk("rr_data", 32'(obs_data[k]), 32'(100 * (obs_id[k] + 1) - 1));
        end

        // Backpressure on a requester-1 stream
        clear_obs();
        exp_q.delete();
        a1 = rnd16(); b1 = rnd16();
        req_valid[1] = 1'b1; req_a[31:16] = a1; req_b[31:16] = b1;
        for (int c = 0; c < 20; c++) begin
            res_ready = !(c >= 6 && c < 11);
            if (c == 8) chk("bp_stall_ready", 32'(req_ready[1]), 32'd0);
            tick();
            if (acc[1]) begin
                exp_q.push_back(qmul(a1, b1));
                a1 = rnd16(); b1 = rnd16();
                req_a[31:16] = a1; req_b[31:16] = b1;
            end
        end
        req_valid[1] = 1'b0;
        drain();
        chk("bp_count", 32'(obs_id.size()), 32'(exp_q.size()));
        for (int k = 0; k < obs_id.size() && k < exp_q.size(); k++) begin
            chk("bp_id", 32'(obs_id[k]), 32'd1);
            chk("bp_data", 32'(obs_data[k]), 32'(exp_q[k]));
        end

        // Asynchronous reset with both stages full
        res_ready = 1'b1;
        req_valid = 4'b0011;
        req_a = {4{16'h1234}}; req_b = {4{16'h2345}};
        repeat (3) tick();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_req_ready", 32'(req_ready), 32'd0);
        clear_obs();
        req_valid = 4'b1001;
        req_a[15:0] = 16'h4000; req_b[15:0] = 16'h2000;
        req_a[63:48] = 16'h2000; req_b[63:48] = 16'h2000;
        @(negedge clk);
        tick();
        rst = 1'b0;
        #1;
        chk("arst_ptr_zero", 32'(req_ready), 32'b0001);
        n = 0;
        while (req_valid != 0 && n < 20) begin
            tick();
            req_valid = req_valid & ~acc;
            n++;
        end
        if (n >= 20) chk("arst_accept_timeout", 32'(n), 32'd0);
        drain();
        chk("arst_count", 32'(obs_id.size()), 32'd2);
        if (obs_id.size() >= 2) begin
            chk("arst_first_id", 32'(obs_id[0]), 32'd0);
            chk("arst_second_id", 32'(obs_id[1]), 32'd3);
            chk("arst_first_data", 32'(obs_data[0]), 32'h1000);
        end

        // Withdrawal during a stall
        clear_obs();
        res_ready = 1'b0;
        send(1, 16'h0100, 16'h4000);
        tick();
        req_valid[3] = 1'b1; req_a[63:48] = 16'h7777; req_b[63:48] = 16'h1111;
        repeat (3) tick();
        req_valid[3] = 1'b0;
        tick();
        drain();
        n3 = 0;
        foreach (obs_id[k]) if (obs_id[k] == 3) n3++;
        chk("withdraw_no_id3", 32'(n3), 32'd0);
        chk("withdraw_count", 32'(obs_id.size()), 32'd1);

        // Randomized traffic with random backpressure and withdrawals
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = ($urandom_range(0, 2) != 0);
                    req_a[16*i +: 16] = rnd16();
                    req_b[16*i +: 16] = rnd16();
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        drain();
        chk("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
